reg_file_mp: RTL and testbench

//  Parametrised multi-port register file for the multi-cycle CPU datapath; next generation of RegFile.
//  N combinational read ports and two write ports: port 0 for ALU writeback, port 1 for DM writeback.

---
 rtl/reg_file_mp_pkg.sv | 15 +
 rtl/rf_write_merge.sv | 36 +++
 rtl/reg_file_mp.sv | 111 +++++++++++
 tb/tb_reg_file_mp.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the multi-port register file and its users in the
// datapath and control: default width/depth, the hardwired-zero register
// address and a byte-count helper.
package reg_file_mp_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned REG_ZERO  = 0;

  // Number of byte lanes in a word of width w (w is a multiple of 8).
  function automatic int unsigned rf_bytes(input int unsigned w);
    return w / 8;
  endfunction

endpackage

// File: rtl/rf_write_merge.sv
// Per-byte merge of a stored register value with the two write ports.
// Bytes are taken from the old value, then overlaid by port 0 (ALU) and
// finally by port 1 (DM), so port 1 wins on bytes both ports enable.
// Ports:
//   old_val            current stored value
//   hit0/wr0_data/be   port 0 targets this register, its data and byte enables
//   hit1/wr1_data/be   port 1 targets this register, its data and byte enables
//   new_val            post-edge value of the register
module rf_write_merge
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic [DATA_W-1:0]   old_val,
  input  logic                hit0,
  input  logic [DATA_W-1:0]   wr0_data,
  input  logic [DATA_W/8-1:0] wr0_be,
  input  logic                hit1,
  input  logic [DATA_W-1:0]   wr1_data,
  input  logic [DATA_W/8-1:0] wr1_be,
  output logic [DATA_W-1:0]   new_val
);

  localparam int unsigned NB = rf_bytes(DATA_W);

  always_comb begin
    new_val = old_val;
    for (int unsigned b = 0; b < NB; b++) begin
      if (hit0 && wr0_be[b]) new_val[b*8 +: 8] = wr0_data[b*8 +: 8];
    end
    for (int unsigned b = 0; b < NB; b++) begin
      if (hit1 && wr1_be[b]) new_val[b*8 +: 8] = wr1_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file for the multi-cycle CPU datapath.
// NUM_RD combinational read ports, two byte-enabled write ports (0: ALU,
// 1: DM), a per-register busy scoreboard and optional write-to-read bypass.
// Ports:
//   CLK, Reset                 clock (rising edge), async active-low reset
//   rd_addr/rd_data/rd_busy    packed read ports, port k at slice k
//   wr0_* / wr1_*              ALU / DM write port: enable, address, data, byte enables
//   issue_en/issue_addr        mark destination register busy
//   flush                      clear every busy bit
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic [DATA_W/8-1:0]      wr0_be,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [DATA_W/8-1:0]      wr1_be,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs   [DEPTH];
  logic [DATA_W-1:0] merged [DEPTH];
  logic [DEPTH-1:0]  busy, busy_nxt, busy_byp;
  logic [DEPTH-1:0]  hit0, hit1, wr_hit, iss_hit;

  // One merge per register: the same merged value feeds both the storage
  // update and the bypass read path.
  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    localparam bit LOCKED = (ZERO_REG != 0) && (r == REG_ZERO);

    assign hit0[r]    = !LOCKED && wr0_en && (wr0_addr == ADDR_W'(r));
    assign hit1[r]    = !LOCKED && wr1_en && (wr1_addr == ADDR_W'(r));
    assign iss_hit[r] = !LOCKED && issue_en && (issue_addr == ADDR_W'(r));

    rf_write_merge #(.DATA_W(DATA_W)) u_merge (
      .old_val  (regs[r]),
      .hit0     (hit0[r]),
      .wr0_data (wr0_data),
      .wr0_be   (wr0_be),
      .hit1     (hit1[r]),
      .wr1_data (wr1_data),
      .wr1_be   (wr1_be),
      .new_val  (merged[r])
    );
  end

  // A write clears busy even when all its byte enables are low.
  assign wr_hit = hit0 | hit1;

  always_comb begin
    busy_nxt = busy;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (iss_hit[r])     busy_nxt[r] = 1'b1;
      else if (flush)     busy_nxt[r] = 1'b0;
      else if (wr_hit[r]) busy_nxt[r] = 1'b0;
    end
  end

  // Bypassed busy reflects only the writeback clear; flush is not forwarded.
  assign busy_byp = busy & ~(wr_hit & ~iss_hit);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= merged[r];
      busy <= busy_nxt;
    end
  end

  // Outputs are forced to zero while reset is held so the bypass path
  // cannot leak write data during reset.
  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a = rd_addr[k*ADDR_W +: ADDR_W];
      if (Reset) begin
        if (BYPASS != 0) begin
          rd_data[k*DATA_W +: DATA_W] = merged[a];
          rd_busy[k]                  = busy_byp[a];
        end else begin
          rd_data[k*DATA_W +: DATA_W] = regs[a];
          rd_busy[k]                  = busy[a];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  typedef struct packed {
    logic            w0en;
    logic [4:0]      w0a;
    logic [63:0]     w0d;
    logic [7:0]      w0be;
    logic            w1en;
    logic [4:0]      w1a;
    logic [63:0]     w1d;
    logic [7:0]      w1be;
    logic            isen;
    logic [4:0]      isa;
    logic            fl;
    logic [2:0][4:0] ra;
  } txn_t;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  // DUT A: default configuration (32b, 32 regs, 2 read ports, bypass)
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr0_en, a_wr1_en, a_issue_en, a_flush;
  logic [4:0]  a_wr0_addr, a_wr1_addr, a_issue_addr;
  logic [31:0] a_wr0_data, a_wr1_data;
  logic [3:0]  a_wr0_be, a_wr1_be;

  // DUT B: 64b, 16 regs, 3 read ports, no bypass
  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_wr0_en, b_wr1_en, b_issue_en, b_flush;
  logic [3:0]   b_wr0_addr, b_wr1_addr, b_issue_addr;
  logic [63:0]  b_wr0_data, b_wr1_data;
  logic [7:0]   b_wr0_be, b_wr1_be;

  reg_file_mp u_dut (
    .CLK(CLK), .Reset(Reset),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr0_en(a_wr0_en), .wr0_addr(a_wr0_addr), .wr0_data(a_wr0_data), .wr0_be(a_wr0_be),
    .wr1_en(a_wr1_en), .wr1_addr(a_wr1_addr), .wr1_data(a_wr1_data), .wr1_be(a_wr1_be),
    .issue_en(a_issue_en), .issue_addr(a_issue_addr), .flush(a_flush)
  );

  reg_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .BYPASS(0)) u_sw (
    .CLK(CLK), .Reset(Reset),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data), .wr0_be(b_wr0_be),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data), .wr1_be(b_wr1_be),
    .issue_en(b_issue_en), .issue_addr(b_issue_addr), .flush(b_flush)
  );

  // Reference model: mreg/mbusy[config][register]
  logic [63:0] mreg  [2][32];
  bit          mbusy [2][32];
  logic [63:0] obs_d [3];
  logic [63:0] obs_b [3];
  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) begin
        mreg[c][r]  = '0;
        mbusy[c][r] = 1'b0;
      end
  endtask

  function automatic bit written(input txn_t t, input logic [4:0] a);
    return (a != 0) && ((t.w0en && t.w0a == a) || (t.w1en && t.w1a == a));
  endfunction

  function automatic bit issued(input txn_t t, input logic [4:0] a);
    return (a != 0) && t.isen && (t.isa == a);
  endfunction

  // Register value after the edge: stored bytes, then port 0, then port 1.
  function automatic logic [63:0] post_val(input int c, input txn_t t, input logic [4:0] a);
    logic [63:0] v;
    int nb;
    nb = (c == 0) ? 4 : 8;
    if (a == 0) return '0;
    v = mreg[c][a];
    for (int b = 0; b < nb; b++)
      if (t.w0en && t.w0a == a && t.w0be[b]) v[b*8 +: 8] = t.w0d[b*8 +: 8];
    for (int b = 0; b < nb; b++)
      if (t.w1en && t.w1a == a && t.w1be[b]) v[b*8 +: 8] = t.w1d[b*8 +: 8];
    return v;
  endfunction

  task automatic drive_a(input txn_t t);
    a_wr0_en = t.w0en; a_wr0_addr = t.w0a; a_wr0_data = t.w0d[31:0]; a_wr0_be = t.w0be[3:0];
    a_wr1_en = t.w1en; a_wr1_addr = t.w1a; a_wr1_data = t.w1d[31:0]; a_wr1_be = t.w1be[3:0];
    a_issue_en = t.isen; a_issue_addr = t.isa; a_flush = t.fl;
    a_rd_addr = {t.ra[1], t.ra[0]};
  endtask

  task automatic drive_b(input txn_t t);
    b_wr0_en = t.w0en; b_wr0_addr = t.w0a[3:0]; b_wr0_data = t.w0d; b_wr0_be = t.w0be;
    b_wr1_en = t.w1en; b_wr1_addr = t.w1a[3:0]; b_wr1_data = t.w1d; b_wr1_be = t.w1be;
    b_issue_en = t.isen; b_issue_addr = t.isa[3:0]; b_flush = t.fl;
    b_rd_addr = {t.ra[2][3:0], t.ra[1][3:0], t.ra[0][3:0]};
  endtask

  // One clock cycle on config c (the other DUT idles); checks every read port.
  task automatic step(input int c, input txn_t t);
    logic [63:0] ed;
    bit eb;
    logic [4:0] a;
    int nrd;
    int depth;
    @(negedge CLK);
    if (c == 0) begin drive_a(t); drive_b('0); end
    else        begin drive_a('0); drive_b(t); end
    #1;
    nrd = (c == 0) ? 2 : 3;
    for (int k = 0; k < nrd; k++) begin
      a = t.ra[k];
      if (c == 0) begin
        ed = post_val(c, t, a);
        eb = mbusy[c][a] && !(written(t, a) && !issued(t, a));
        obs_d[k] = {32'h0, a_rd_data[k*32 +: 32]};
        obs_b[k] = {63'h0, a_rd_busy[k]};
      end else begin
        ed = mreg[c][a];
        eb = mbusy[c][a];
        obs_d[k] = b_rd_data[k*64 +: 64];
        obs_b[k] = {63'h0, b_rd_busy[k]};
      end
      chk($sformatf("cfg%0d rd%0d data r%0d", c, k, a), obs_d[k], ed);
      chk($sformatf("cfg%0d rd%0d busy r%0d", c, k, a), obs_b[k], {63'h0, eb});
    end
    @(posedge CLK);
    depth = (c == 0) ? 32 : 16;
    for (int r = 0; r < depth; r++) begin
      a = 5'(r);
      mreg[c][r] = post_val(c, t, a);
      if (issued(t, a))       mbusy[c][r] = 1'b1;
      else if (t.fl)          mbusy[c][r] = 1'b0;
      else if (written(t, a)) mbusy[c][r] = 1'b0;
    end
  endtask

  function automatic logic [4:0] raddr(input int c);
    int unsigned depth;
    depth = (c == 0) ? 32 : 16;
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, depth - 1));
    return 5'($urandom_range(0, 5));
  endfunction

  function automatic txn_t rand_txn(input int c);
    txn_t t;
    t = '0;
    t.w0en = 1'($urandom_range(0, 1)); t.w0a = raddr(c);
    t.w0d = {$urandom, $urandom}; t.w0be = 8'($urandom);
    t.w1en = 1'($urandom_range(0, 1)); t.w1a = raddr(c);
    t.w1d = {$urandom, $urandom}; t.w1be = 8'($urandom);
    t.isen = ($urandom_range(0, 2) == 0); t.isa = raddr(c);
    t.fl = ($urandom_range(0, 9) == 0);
    for (int k = 0; k < 3; k++) t.ra[k] = raddr(c);
    return t;
  endfunction

  initial begin
    txn_t t;
    clear_model();
    // Reset held: a write and issue with bypass must stay invisible.
    Reset = 1'b0;
    t = '0; t.w0en = 1; t.w0a = 2; t.w0d = 64'hFFFF_FFFF; t.w0be = 8'hFF;
    t.isen = 1; t.isa = 2; t.ra[0] = 2; t.ra[1] = 2;
    drive_a(t); drive_b('0);
    #1;
    chk("reset rd_data", a_rd_data, 64'h0);
    chk("reset rd_busy", {62'h0, a_rd_busy}, 64'h0);
    @(negedge CLK);
    drive_a('0);
    Reset = 1'b1;

    // Basic write then read
    t = '0; t.w0en = 1; t.w0a = 2; t.w0d = 64'd1; t.w0be = 8'h0F; t.ra[0] = 2;
    step(0, t);
    t = '0; t.ra[0] = 2;
    step(0, t);
    chk("r2 read", obs_d[0], 64'd1);
    t = '0; t.w0en = 1; t.w0a = 1; t.w0d = 64'h1234; t.w0be = 8'h0F; t.ra[0] = 1;
    step(0, t);
    chk("r1 bypass", obs_d[0], 64'h1234);

    // Byte merge collision
    t = '0; t.w1en = 1; t.w1a = 5; t.w1d = 64'hAABBCCDD; t.w1be = 8'h0F;
    step(0, t);
    t = '0; t.w0en = 1; t.w0a = 5; t.w0d = 64'h11111111; t.w0be = 8'h03;
    t.w1en = 1; t.w1a = 5; t.w1d = 64'h22222222; t.w1be = 8'h06; t.ra[0] = 5;
    step(0, t);
    chk("collision bypass", obs_d[0], 64'hAA222211);
    t = '0; t.ra[1] = 5;
    step(0, t);
    chk("collision stored", obs_d[1], 64'hAA222211);

    // Zero register
    t = '0; t.w1en = 1; t.w1a = 0; t.w1d = 64'd4; t.w1be = 8'h0F; t.isen = 1; t.isa = 0;
    step(0, t);
    t = '0;
    step(0, t);
    chk("r0 data p0", obs_d[0], 64'h0);
    chk("r0 data p1", obs_d[1], 64'h0);
    chk("r0 busy p0", obs_b[0], 64'h0);
    chk("r0 busy p1", obs_b[1], 64'h0);

    // Scoreboard
    t = '0; t.isen = 1; t.isa = 3; t.ra[0] = 3;
    step(0, t);
    t = '0; t.ra[0] = 3;
    step(0, t);
    chk("issue sets busy", obs_b[0], 64'h1);
    t = '0; t.w0en = 1; t.w0a = 3; t.w0d = 64'h77; t.w0be = 8'h00; t.ra[0] = 3;
    step(0, t);
    chk("write clears busy bypass", obs_b[0], 64'h0);
    t = '0; t.isen = 1; t.isa = 3; t.w1en = 1; t.w1a = 3; t.w1d = 64'h99; t.w1be = 8'h0F;
    step(0, t);
    t = '0; t.ra[0] = 3; t.ra[1] = 3;
    step(0, t);
    chk("issue+write stays busy", obs_b[1], 64'h1);
    t = '0; t.isen = 1; t.isa = 4;
    step(0, t);
    t = '0; t.fl = 1; t.ra[0] = 3; t.ra[1] = 4;
    step(0, t);
    t = '0; t.ra[0] = 3; t.ra[1] = 4;
    step(0, t);
    chk("flush r3", obs_b[0], 64'h0);
    chk("flush r4", obs_b[1], 64'h0);

    // Sweep instance: no bypass, new value one cycle later
    t = '0; t.w0en = 1; t.w0a = 9; t.w0d = 64'h0123456789ABCDEF; t.w0be = 8'hFF; t.ra[2] = 9;
    step(1, t);
    chk("sweep old value", obs_d[2], 64'h0);
    t = '0; t.ra[2] = 9;
    step(1, t);
    chk("sweep new value", obs_d[2], 64'h0123456789ABCDEF);

    // Randomised traffic against the model
    repeat (250) step(0, rand_txn(0));
    repeat (150) step(1, rand_txn(1));

    // Reset asserted mid-cycle after a write and issue
    t = '0; t.w0en = 1; t.w0a = 2; t.w0d = 64'd1; t.w0be = 8'h0F; t.isen = 1; t.isa = 7;
    step(0, t);
    #2;
    Reset = 1'b0;
    a_rd_addr = {5'd7, 5'd2};
    #1;
    chk("mid reset data", a_rd_data, 64'h0);
    chk("mid reset busy", {62'h0, a_rd_busy}, 64'h0);
    clear_model();
    @(negedge CLK);
    drive_a('0); drive_b('0);
    Reset = 1'b1;
    t = '0; t.ra[0] = 2; t.ra[1] = 7;
    step(0, t);
    chk("post reset r2", obs_d[0], 64'h0);
    chk("post reset busy r7", obs_b[1], 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
